lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter MEM_LATENCY, default 1, SHALL be the number of cycles from the mem_load pulse to valid mem_rdata; legal range 1..7.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_valid  input  1  SHALL flag a CPU memory request.
REQ-005 req_ready  output  1  SHALL flag that the LSU accepts a request this cycle.
REQ-006 req_store  input  1  SHALL select store (1) or load (0).
REQ-007 req_access  input  3  SHALL carry the width/sign code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-008 req_addr  input  32  SHALL carry the byte address.
REQ-009 req_wdata  input  32  SHALL carry the store data.
REQ-010 resp_valid  output  1  SHALL flag a completed request.
REQ-011 resp_ready  input  1  SHALL flag that the CPU takes the response.
REQ-012 resp_data  output  32  SHALL carry the load result; 0 for stores and faults.
REQ-013 resp_fault  output  1  SHALL flag an illegal or trapped request.
REQ-014 mem_load, mem_store  output  1 each  SHALL be the one-cycle load/store strobes to the memory responder.
REQ-015 mem_access  output  3, mem_addr  output  32, mem_wdata  output  32  SHALL be the latched request fields.
REQ-016 mem_rdata  input  32  SHALL be the responder's read data, already sized and extended per access.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE with req_valid=1, the LSU SHALL latch req_store, req_access, req_addr and req_wdata at the edge.
- A legal request goes to ISSUE.
- A faulting request goes to RESP with resp_fault=1 and no memory strobe.
REQ-019 Legal codes:
- loads: 000, 001, 010, 100, 101.
- stores: 000, 001, 010.
- Every other code (including store 100/101) SHALL fault.
REQ-020 ISSUE SHALL last exactly one cycle, with mem_load=1 (load) or mem_store=1 (store).
- A store then goes to RESP.
- A load then goes to WAIT.
REQ-021 WAIT SHALL last exactly MEM_LATENCY cycles, counted by a 3-bit counter.
- mem_rdata SHALL be captured into resp_data at the edge that ends WAIT.
- The FSM then goes to RESP.
REQ-022 mem_access, mem_addr and mem_wdata SHALL hold the latched values in ISSUE, WAIT and RESP, and SHALL be 0 in IDLE.
REQ-023 In RESP, resp_valid SHALL be 1 and resp_data/resp_fault SHALL be stable until resp_ready=1, then the FSM SHALL return to IDLE.
REQ-024 Latency from the accept edge:
- fault: resp_valid in the next cycle.
- store: resp_valid 2 cycles later.
- load: resp_valid 2+MEM_LATENCY cycles later.
- At least one IDLE cycle SHALL separate consecutive requests.
REQ-025 req_valid outside IDLE SHALL be ignored; inputs changing after acceptance SHALL NOT affect the outstanding request.

Reset
REQ-026 rst=0 SHALL immediately set the FSM to IDLE and drive the following outputs to 0:
- resp_valid, resp_data, resp_fault.
- mem_load, mem_store, mem_access, mem_addr, mem_wdata.
- req_ready SHALL be 0 while rst=0 and 1 from the first cycle after release.
REQ-027 Reset during ISSUE, WAIT or RESP SHALL discard the outstanding request; no response SHALL be produced for it.

Configuration
REQ-028 With macro LSU_MISALIGN_TRAP_EN defined, a misaligned request SHALL fault per REQ-018.
- misaligned half: addr[0]=1.
- misaligned word: addr[1:0]!=0.
REQ-029 Without LSU_MISALIGN_TRAP_EN, misaligned requests SHALL be issued to memory unmodified, and only illegal codes SHALL fault.

Verification
REQ-030 Load, MEM_LATENCY=1: LW addr 0x100, mem_rdata=0xDEADBEEF -> mem_load is high exactly one cycle; resp_valid=1 three cycles after accept with resp_data=0xDEADBEEF, resp_fault=0.
REQ-031 Store SB: addr 0x103, wdata 0x000000AA -> mem_store is one cycle with mem_access=000, mem_addr=0x103; resp_valid two cycles after accept with resp_data=0.
REQ-032 Illegal store, access=100 -> resp_fault=1 one cycle after accept; mem_load and mem_store are never asserted.
REQ-033 LH addr 0x102 then LW addr 0x101:
- with LSU_MISALIGN_TRAP_EN: LH completes normally; LW faults with no strobe.
- without the macro: both issue.
REQ-034 Backpressure and reset:
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stay stable and req_ready=0.
- Assert rst=0 mid-WAIT (MEM_LATENCY=4) -> all outputs 0 immediately, and no response after release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: accepts one CPU memory request at a time, issues a one-cycle strobe
// and returns a response. Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module lsu #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_access,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic        mem_load,
  output logic        mem_store,
  output logic [2:0]  mem_access,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  access_q, access_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;
  logic [2:0]  cnt_q, cnt_d;

  logic misal_half, misal_word, req_fault;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal_half = req_addr[0];
  assign misal_word = |req_addr[1:0];
`else
  assign misal_half = 1'b0;
  assign misal_word = 1'b0;
`endif

  // Unsigned codes are load-only; every unlisted code is illegal.
  always_comb begin
    req_fault = 1'b1;
    case (req_access)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = misal_half;
      3'b010:  req_fault = misal_word;
      3'b100:  req_fault = req_store;
      3'b101:  req_fault = req_store | misal_half;
      default: req_fault = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    access_d = access_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d  = req_store;
          access_d = req_access;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          data_d   = 32'h0;
          fault_d  = req_fault;
          state_d  = req_fault ? StResp : StIssue;
        end
      end
      StIssue: begin
        if (store_q) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = 3'(MEM_LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          data_d  = mem_rdata;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      access_q <= 3'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      data_q   <= 32'h0;
      fault_q  <= 1'b0;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      access_q <= access_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  // Reset forces the state to idle, so ready is also gated by the reset level itself.
  logic busy;
  always_comb begin
    busy       = (state_q != StIdle);
    req_ready  = (state_q == StIdle) & rst;
    resp_valid = (state_q == StResp);
    resp_data  = resp_valid ? data_q : 32'h0;
    resp_fault = resp_valid & fault_q;
    mem_load   = (state_q == StIssue) & ~store_q;
    mem_store  = (state_q == StIssue) & store_q;
    mem_access = busy ? access_q : 3'b0;
    mem_addr   = busy ? addr_q : 32'h0;
    mem_wdata  = busy ? wdata_q : 32'h0;
  end

endmodule
